// File: rtl/vpu_inst_queue.sv
// Vector instruction queue.
// A small in-order FIFO between the decode buffer and the vector execution units.
// It holds decoded uOPs in a circular buffer of DEPTH entries.
// Reset and flush both empty the queue.
// There is no bypass path: a uOP is visible at the head one cycle after it is accepted.

package vpu_inst_queue_pkg;

   // Decoded vector micro-operation as produced by the decode stage.
   typedef struct packed {
      logic [5:0]  opcode;
      logic [2:0]  funct3;
      logic [4:0]  vd;
      logic [4:0]  vs1;
      logic [4:0]  vs2;
      logic        vm;
      logic [31:0] scalar;
   } VPU_uOP_t;

endpackage

module vpu_inst_queue
   import vpu_inst_queue_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             decode_entry_valid_i,
   input  VPU_uOP_t         decode_entry_i,
   output logic             decode_ack_o,
   output logic             issue_valid_o,
   output VPU_uOP_t         issue_uop_o,
   input  logic             issue_ready_i,
   input  logic             flush_i,
   output logic             queue_empty_o,
   output logic             queue_full_o,
   output logic [CNT_W-1:0] queue_count_o
);

   localparam int PTR_W = $clog2(DEPTH);

   // Pointers and occupancy counter (registered state).
   logic [PTR_W-1:0] wr_ptr_reg;
   logic [PTR_W-1:0] wr_ptr_next;
   logic [PTR_W-1:0] rd_ptr_reg;
   logic [PTR_W-1:0] rd_ptr_next;
   logic [CNT_W-1:0] count_reg;
   logic [CNT_W-1:0] count_next;

   // Entry storage. It is never reset, because the pointers alone define which entries are live.
   VPU_uOP_t         mem [DEPTH];
   logic [DEPTH-1:0] entry_we;

   // Status flags and handshake qualifiers.
   logic full;
   logic empty;
   logic push;
   logic pop;

   // The status flags come only from the counter, so no input reaches them combinationally.
   assign full  = (count_reg == CNT_W'(DEPTH));
   assign empty = (count_reg == '0);

   // Acceptance looks only at the registered full flag.
   // A full queue therefore never accepts in the same cycle as it pops; the ack returns one cycle later.
   assign push = decode_entry_valid_i && !full && !flush_i;
   assign pop  = !empty && issue_ready_i && !flush_i;

   assign decode_ack_o  = push;
   assign issue_valid_o = !empty;
   assign issue_uop_o   = mem[rd_ptr_reg];
   assign queue_empty_o = empty;
   assign queue_full_o  = full;
   assign queue_count_o = count_reg;

   // Next-state computation for the pointers and the occupancy count.
   always_comb begin
      wr_ptr_next = wr_ptr_reg;
      rd_ptr_next = rd_ptr_reg;
      count_next  = count_reg;
      if (flush_i) begin
         wr_ptr_next = '0;
         rd_ptr_next = '0;
         count_next  = '0;
      end else begin
         if (push) begin
            wr_ptr_next = wr_ptr_reg + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr_next = rd_ptr_reg + PTR_W'(1);
         end
         unique case ({push, pop})
            2'b10:   count_next = count_reg + CNT_W'(1);
            2'b01:   count_next = count_reg - CNT_W'(1);
            default: count_next = count_reg;
         endcase
      end
   end

   // State register. Reset takes priority over flush, push and pop.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         wr_ptr_reg <= wr_ptr_next;
         rd_ptr_reg <= rd_ptr_next;
         count_reg  <= count_next;
      end
   end

   // One write enable per slot, and one register per slot.
   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
         assign entry_we[gi] = push && !rst_i && (wr_ptr_reg == PTR_W'(gi));

         // Capture the incoming uOP into this slot when the write pointer selects it.
         always_ff @(posedge clk_i) begin
            if (entry_we[gi]) begin
               mem[gi] <= decode_entry_i;
            end
         end
      end
   endgenerate

endmodule

// File: tb/tb_vpu_inst_queue.sv
// Self-checking bench for vpu_inst_queue.
// The bench keeps a scoreboard queue of accepted uOPs.
// The head of the DUT queue is compared against the scoreboard every cycle, and an entry is retired when it is popped.

module tb_vpu_inst_queue;
   import vpu_inst_queue_pkg::*;

   localparam int DEPTH = 4;
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic             clk_i = 1'b0;
   logic             rst_i = 1'b1;
   logic             decode_entry_valid_i = 1'b0;
   VPU_uOP_t         decode_entry_i = '0;
   logic             decode_ack_o;
   logic             issue_valid_o;
   VPU_uOP_t         issue_uop_o;
   logic             issue_ready_i = 1'b0;
   logic             flush_i = 1'b0;
   logic             queue_empty_o;
   logic             queue_full_o;
   logic [CNT_W-1:0] queue_count_o;

   int checks = 0;
   int errors = 0;
   bit verbose = 1'b1;

   VPU_uOP_t exp_q[$];

   vpu_inst_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk_i                (clk_i),
      .rst_i                (rst_i),
      .decode_entry_valid_i (decode_entry_valid_i),
      .decode_entry_i       (decode_entry_i),
      .decode_ack_o         (decode_ack_o),
      .issue_valid_o        (issue_valid_o),
      .issue_uop_o          (issue_uop_o),
      .issue_ready_i        (issue_ready_i),
      .flush_i              (flush_i),
      .queue_empty_o        (queue_empty_o),
      .queue_full_o         (queue_full_o),
      .queue_count_o        (queue_count_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h expected=%h", tag, got, exp);
      end
   endtask

   function automatic VPU_uOP_t rand_uop();
      logic [63:0] r;
      r = {$urandom(), $urandom()};
      return r[$bits(VPU_uOP_t)-1:0];
   endfunction

   // One clock cycle.
   // The task drives inputs just after the rising edge and checks the outputs at the falling edge.
   // It then updates the model across the next rising edge.
   task automatic step(input logic v, input VPU_uOP_t u, input logic r, input logic f, input logic rs);
      bit exp_ack;
      bit exp_pop;
      VPU_uOP_t head;
      decode_entry_valid_i = v;
      decode_entry_i       = u;
      issue_ready_i        = r;
      flush_i              = f;
      rst_i                = rs;
      #4;
      exp_ack = v && (exp_q.size() < DEPTH) && !f;
      exp_pop = (exp_q.size() != 0) && r && !f;
      check("ack", 64'(decode_ack_o), 64'(exp_ack));
      check("issue_valid", 64'(issue_valid_o), 64'(exp_q.size() != 0));
      check("count", 64'(queue_count_o), 64'(exp_q.size()));
      check("full", 64'(queue_full_o), 64'(exp_q.size() == DEPTH));
      check("empty", 64'(queue_empty_o), 64'(exp_q.size() == 0));
      if (exp_q.size() != 0) begin
         check("issue_uop", 64'(issue_uop_o), 64'(exp_q[0]));
      end
      @(posedge clk_i);
      #1;
      if (rs || f) begin
         if (verbose) $display("%0t %s: queue cleared", $time, rs ? "reset" : "flush");
         exp_q.delete();
      end else begin
         if (exp_pop) begin
            head = exp_q.pop_front();
            if (verbose) $display("%0t pop  %h", $time, head);
         end
         if (exp_ack) begin
            exp_q.push_back(u);
            if (verbose) $display("%0t push %h", $time, u);
         end
      end
   endtask

   initial begin
      VPU_uOP_t a;
      VPU_uOP_t b;
      VPU_uOP_t c;
      VPU_uOP_t d;
      VPU_uOP_t x;
      // Hold reset for two edges before checking anything, so the state is known.
      repeat (2) @(posedge clk_i);
      #1;
      exp_q.delete();
      // Check the reset state while reset is still asserted.
      step(1'b0, '0, 1'b1, 1'b0, 1'b1);

      // Push A, B and C with the consumer stalled.
      a = rand_uop(); b = rand_uop(); c = rand_uop();
      step(1'b1, a, 1'b0, 1'b0, 1'b0);
      step(1'b1, b, 1'b0, 1'b0, 1'b0);
      step(1'b1, c, 1'b0, 1'b0, 1'b0);
      step(1'b0, '0, 1'b0, 1'b0, 1'b0);
      check("count_abc", 64'(queue_count_o), 64'd3);
      check("head_a", 64'(issue_uop_o), 64'(a));

      // Fill the queue, hold valid while full, then pop once.
      x = rand_uop();
      step(1'b1, x, 1'b0, 1'b0, 1'b0);
      check("full_at_4", 64'(queue_full_o), 64'd1);
      step(1'b1, rand_uop(), 1'b0, 1'b0, 1'b0);
      step(1'b1, rand_uop(), 1'b1, 1'b0, 1'b0);
      step(1'b1, rand_uop(), 1'b0, 1'b0, 1'b0);
      check("refill_4", 64'(queue_count_o), 64'd4);

      // Drain to two entries, then push and pop together for ten cycles.
      step(1'b0, '0, 1'b1, 1'b0, 1'b0);
      step(1'b0, '0, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 10; i++) begin
         step(1'b1, rand_uop(), 1'b1, 1'b0, 1'b0);
      end
      check("steady_2", 64'(queue_count_o), 64'd2);

      // Flush at a count of three, with valid and ready both high.
      step(1'b1, rand_uop(), 1'b0, 1'b0, 1'b0);
      step(1'b1, rand_uop(), 1'b1, 1'b1, 1'b0);
      d = rand_uop();
      step(1'b1, d, 1'b0, 1'b0, 1'b0);
      step(1'b0, '0, 1'b0, 1'b0, 1'b0);
      check("after_flush_head", 64'(issue_uop_o), 64'(d));

      // Reset mid-operation at a count of two, then push D again.
      step(1'b1, rand_uop(), 1'b0, 1'b0, 1'b0);
      step(1'b0, '0, 1'b1, 1'b0, 1'b1);
      d = rand_uop();
      step(1'b1, d, 1'b0, 1'b0, 1'b0);
      step(1'b0, '0, 1'b1, 1'b0, 1'b0);
      step(1'b0, '0, 1'b0, 1'b0, 1'b0);

      // Random traffic against the scoreboard.
      verbose = 1'b0;
      for (int i = 0; i < 10000; i++) begin
         step(($urandom % 4) != 0, rand_uop(), ($urandom % 2) != 0,
              ($urandom % 64) == 0, ($urandom % 512) == 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
